regfile: RTL and testbench
==========================

Name: regfile

Overview:
- General-purpose register file and consumer of the write-back bus driven by the MEM/WB pipeline register (we, waddr, wdata).
- Provides two combinational read ports to the decode stage, with write-to-read bypass so decode sees the value written back in the same cycle.
- After reset, a clear sequencer zeroes every architectural register. `ready` tells the pipeline when the block may be used.

Parameters:
- DATA_W, 32, register and data width.
- ADDR_W, 5, register address width. Number of registers NREGS = 2**ADDR_W.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- we  in  1  write-back write enable (from wb_wreg).
- waddr  in  ADDR_W  write-back destination register (from wb_wd).
- wdata  in  DATA_W  write-back data (from wb_wdata).
- re1  in  1  read port 1 enable.
- raddr1  in  ADDR_W  read port 1 address.
- rdata1  out  DATA_W  read port 1 data, combinational.
- re2  in  1  read port 2 enable.
- raddr2  in  ADDR_W  read port 2 address.
- rdata2  out  DATA_W  read port 2 data, combinational.
- ready  out  1  registered; 1 when the clear sequence is complete and the block is usable.
- wr_drop  out  1  registered; one-cycle pulse when a write-back is discarded during CLEAR.

Behaviour:
- Reset and clock: reset rst, synchronous, active-high; clock clk. All state updates on the rising edge of clk.
- Reset values of outputs: while rst=1, ready=0 and wr_drop=0. rdata1 and rdata2 are forced to 0 combinationally while rst=1.
- States: CLEAR and READY.
  - Any edge with rst=1: state<=CLEAR, clr_idx<=1. Array contents are not touched during reset itself.
  - CLEAR, rst=0: mem[clr_idx]<=0 and clr_idx<=clr_idx+1.
  - When clr_idx==NREGS-1 is written: state<=READY, ready<=1.
  - Net effect: ready rises on the 31st rising edge with rst low (NREGS-1 edges in general).
  - READY is held until the next reset. Asserting rst mid-clear restarts the sequence from index 1.
- Register 0:
  - Never stored; it always reads 0.
  - A write to waddr=0 has no effect and is not a drop: wr_drop stays 0.
- Write (READY only): if we=1 and waddr!=0, then mem[waddr]<=wdata at the edge. Write latency is 1 edge.
- Write during CLEAR:
  - A write with we=1 is discarded and the array is unchanged.
  - wr_drop<=1 for exactly the following cycle; otherwise wr_drop<=0.
  - The pipeline is required to stall on ready=0. The drop flag exists for verification and assertion use.
- Read port k (k=1,2), combinational, evaluated in priority order:
  1. rst=1 -> 0.
  2. state CLEAR -> 0.
  3. rek=0 -> 0.
  4. raddrk=0 -> 0.
  5. we=1 and waddr==raddrk -> wdata (bypass).
  6. Otherwise -> mem[raddrk].
- Simultaneous events:
  - Both ports may read the same address, including a bypassed address; both return the same value.
  - Write and read to different addresses in the same cycle do not interact.
- Width: no arithmetic on data. clr_idx is ADDR_W bits and its increment is never observed past NREGS-1.
- Storage: an array of NREGS-1 or NREGS entries is allowed; entry 0 is unused.

Test Plan:
- Clear timing: drive rst=1 for 2 edges, then 0 -> ready=0 for 30 edges, ready=1 after the 31st edge. With re1=1, rdata1=0 for all raddr1=0..31.
- Write then read: in READY, write r5=0xDEADBEEF; next cycle raddr1=5, re1=1 -> rdata1=0xDEADBEEF. With re1=0 -> rdata1=0.
- Bypass: same cycle we=1, waddr=7, wdata=0x12345678, raddr1=7, raddr2=7, re1=re2=1 -> rdata1=rdata2=0x12345678. Next cycle without we -> both still 0x12345678.
- r0: write waddr=0, wdata=0xFFFFFFFF -> rdata1 at raddr1=0 is 0 both same-cycle and next cycle; wr_drop=0.
- Drop during clear: 5 edges after rst falls, drive we=1, waddr=20, wdata=0xAAAA5555 -> wr_drop=1 for one cycle. After ready=1, reading r20 returns 0.
- Reset mid-operation: in READY, write r3=0x1; assert rst for 1 edge, release -> ready=0, rdata reads 0; 31 edges later ready=1 and r3 reads 0.

Source files
------------

// File: rtl/regfile.sv
// General-purpose register file: write-back port, two bypassed combinational read ports,
// and a post-reset clear sequencer that zeroes r1..rN-1 before asserting ready.
module regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic              ready,
  output logic              wr_drop
);

  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] clr_idx, clr_idx_next;
  logic              clr_wr;
  logic              wr_en;
  logic              drop;

  logic [DATA_W-1:0] mem [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= ADDR_W'(1);
      ready   <= 1'b0;
      wr_drop <= 1'b0;
    end else begin
      state   <= state_next;
      clr_idx <= clr_idx_next;
      ready   <= (state_next == READY);
      wr_drop <= drop;
    end
  end

  always_comb begin
    state_next   = state;
    clr_idx_next = clr_idx;
    clr_wr       = 1'b0;
    case (state)
      CLEAR: begin
        clr_wr       = 1'b1;
        clr_idx_next = clr_idx + ADDR_W'(1);
        if (clr_idx == LAST_IDX) state_next = READY;
      end
      READY: state_next = READY;
      default: state_next = CLEAR;
    endcase
  end

  assign wr_en = (state == READY) && we && (waddr != '0);
  // Writes to r0 are architecturally void, so they never count as a drop.
  assign drop  = (state == CLEAR) && we && (waddr != '0);

  // Entry 0 is never written, so its contents are irrelevant.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_wr)     mem[clr_idx] <= '0;
      else if (wr_en) mem[waddr]   <= wdata;
    end
  end

  always_comb begin
    rdata1 = '0;
    if (!rst && state == READY && re1 && raddr1 != '0) begin
      if (we && waddr == raddr1) rdata1 = wdata;
      else                       rdata1 = mem[raddr1];
    end
  end

  always_comb begin
    rdata2 = '0;
    if (!rst && state == READY && re2 && raddr2 != '0) begin
      if (we && waddr == raddr2) rdata2 = wdata;
      else                       rdata2 = mem[raddr2];
    end
  end

endmodule

// File: tb/tb_regfile.sv
// Scoreboard bench for regfile: expectations are queued as stimulus is driven and
// drained against the DUT outputs on the falling edge of each cycle.
module tb_regfile;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic        ready;
  logic        wr_drop;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  regfile #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .re1    (re1),
    .raddr1 (raddr1),
    .rdata1 (rdata1),
    .re2    (re2),
    .raddr2 (raddr2),
    .rdata2 (rdata2),
    .ready  (ready),
    .wr_drop(wr_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input string tag, input int sig, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.val = val;
    sb.push_back(e);
  endtask

  // Sample away from the active edge and retire every queued expectation.
  task automatic drain();
    exp_t        e;
    logic [31:0] got;
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sig)
        0:       got = rdata1;
        1:       got = rdata2;
        2:       got = {31'b0, ready};
        default: got = {31'b0, wr_drop};
      endcase
      chk(e.tag, got, e.val);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;

    // Two reset edges; outputs held low, reads forced to zero.
    cyc();
    re1 = 1'b1; raddr1 = 5'd5;
    push_exp("rst_ready", 2, 0);
    push_exp("rst_drop", 3, 0);
    push_exp("rst_rdata1", 0, 0);
    drain();
    cyc();
    rst = 1'b0;

    // Clear sequence with a write injected after the 5th low edge.
    for (int e = 1; e <= 31; e++) begin
      cyc();
      we     = (e == 5);
      waddr  = 5'd20;
      wdata  = 32'hAAAA5555;
      re1    = 1'b1;
      raddr1 = 5'(e);
      push_exp($sformatf("clr_ready_e%0d", e), 2, (e >= 31) ? 32'd1 : 32'd0);
      push_exp($sformatf("clr_drop_e%0d", e), 3, (e == 6) ? 32'd1 : 32'd0);
      push_exp($sformatf("clr_rdata1_e%0d", e), 0, 0);
      drain();
    end
    we = 1'b0;

    // Every register reads zero after clear, including the dropped r20.
    for (int a = 0; a < 32; a++) begin
      cyc();
      re1 = 1'b1; raddr1 = 5'(a);
      push_exp($sformatf("zero_r%0d", a), 0, 0);
      drain();
    end

    // Write r5, read it back with and without enable.
    cyc();
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; re1 = 1'b0; raddr1 = 5'd5;
    push_exp("wr5_re0_same", 0, 0);
    drain();
    cyc();
    we = 1'b0; re1 = 1'b1;
    push_exp("rd5", 0, 32'hDEADBEEF);
    drain();
    cyc();
    re1 = 1'b0;
    push_exp("rd5_re0", 0, 0);
    drain();

    // Bypass on both ports, then the stored value.
    cyc();
    we = 1'b1; waddr = 5'd7; wdata = 32'h12345678;
    re1 = 1'b1; raddr1 = 5'd7; re2 = 1'b1; raddr2 = 5'd7;
    push_exp("byp7_p1", 0, 32'h12345678);
    push_exp("byp7_p2", 1, 32'h12345678);
    drain();
    cyc();
    we = 1'b0;
    push_exp("st7_p1", 0, 32'h12345678);
    push_exp("st7_p2", 1, 32'h12345678);
    drain();

    // Write and read of different addresses in the same cycle.
    cyc();
    we = 1'b1; waddr = 5'd9; wdata = 32'hCAFEF00D; raddr1 = 5'd5; raddr2 = 5'd9;
    push_exp("mix_p1_r5", 0, 32'hDEADBEEF);
    push_exp("mix_p2_byp9", 1, 32'hCAFEF00D);
    drain();
    cyc();
    we = 1'b0; raddr1 = 5'd9; raddr2 = 5'd7;
    push_exp("mix_p1_r9", 0, 32'hCAFEF00D);
    push_exp("mix_p2_r7", 1, 32'h12345678);
    drain();

    // r0 ignores writes and never reports a drop.
    cyc();
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; re1 = 1'b1; raddr1 = 5'd0; re2 = 1'b0;
    push_exp("r0_same", 0, 0);
    drain();
    cyc();
    we = 1'b0;
    push_exp("r0_next", 0, 0);
    push_exp("r0_drop", 3, 0);
    drain();

    // Reset in READY: r3 must be cleared again.
    cyc();
    we = 1'b1; waddr = 5'd3; wdata = 32'h1;
    cyc();
    we = 1'b0; raddr1 = 5'd3;
    push_exp("rd3_pre", 0, 32'h1);
    drain();
    cyc();
    rst = 1'b1;
    push_exp("rd3_in_rst", 0, 0);
    drain();
    cyc();
    rst = 1'b0;
    push_exp("rst2_ready", 2, 0);
    push_exp("rst2_rd3", 0, 0);
    drain();
    for (int e = 1; e <= 31; e++) begin
      cyc();
      push_exp($sformatf("rst2_ready_e%0d", e), 2, (e >= 31) ? 32'd1 : 32'd0);
      push_exp($sformatf("rst2_rd3_e%0d", e), 0, 0);
      drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
